mmu_cmd_scheduler: RTL and testbench

//  Arbitrates MMU access between NUM_REQ command sources (e.g. QKV-proj, attention, MLP engines).

---
 rtl/mmu_cmd_scheduler_pkg.sv | 29 ++
 rtl/mmu_cmd_scheduler_rr_arbiter.sv | 30 +++
 rtl/mmu_cmd_scheduler.sv | 167 ++++++++++++++++
 tb/tb_mmu_cmd_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_cmd_scheduler_pkg.sv
// Shared MMU scheduling types: FSM states, op codes and the per-op result grouping.
package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] OP_DENSE0 = 3'd0;
  localparam logic [2:0] OP_SCALE2 = 3'd1;
  localparam logic [2:0] OP_DENSE2 = 3'd2;
  localparam logic [2:0] OP_PAIR   = 3'd3;
  localparam logic [2:0] OP_SCALE8 = 3'd5;

  // Input beats consumed per MMU result; mmu_valid_ctrl counts with the same rule.
  function automatic logic [6:0] mmu_group(input logic [2:0] op, input logic [1:0] stage);
    logic [6:0] g;
    case (op)
      OP_PAIR:   g = 7'd2;
      OP_SCALE2: g = 7'd2 << stage;
      OP_SCALE8: g = 7'd8 << stage;
      default:   g = 7'd1;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mmu_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward (wrapping) for the first request.
module rr_arbiter #(
  parameter int  NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/mmu_cmd_scheduler.sv
// Grants one command at a time to the MMU, streams it as a contiguous valid burst,
// counts results with a drain timeout, and reports completion with error flags.
module mmu_cmd_scheduler
  import mmu_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  parameter int  BEAT_W  = 12,
  parameter int  TIMEOUT = 255,
  localparam int IDX_W   = $clog2(NUM_REQ),
  localparam int TMO_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*3-1:0]      req_op_code,
  input  logic [NUM_REQ*2-1:0]      req_stage,
  input  logic [NUM_REQ*BEAT_W-1:0] req_beats,
  input  logic                      feed_ready,
  output logic                      mmu_valid_in,
  output logic [2:0]                mmu_op_code,
  output logic [1:0]                mmu_stage,
  input  logic                      mmu_valid_out,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W-1:0]          done_id,
  output logic                      err_cfg,
  output logic                      err_timeout
);

  state_e              state_q;
  logic [IDX_W-1:0]    rr_ptr_q, id_q, done_id_q;
  logic [2:0]          op_q;
  logic [1:0]          stage_q;
  logic [BEAT_W-1:0]   beats_q, exp_q, beat_cnt_q, res_cnt_q;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic                cfg_bad_q, tmo_err_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic                valid_in_q, done_q, err_cfg_q, err_timeout_q;

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic [2:0]          sel_op;
  logic [1:0]          sel_stage;
  logic [BEAT_W-1:0]   sel_beats, sel_grp, res_cnt_d;
  logic                sel_bad, res_met;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    sel_op    = '0;
    sel_stage = '0;
    sel_beats = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op    = req_op_code[i*3 +: 3];
        sel_stage = req_stage[i*2 +: 2];
        sel_beats = req_beats[i*BEAT_W +: BEAT_W];
      end
    end
  end

  assign sel_grp = BEAT_W'(mmu_group(sel_op, sel_stage));
  assign sel_bad = (sel_beats == '0) || ((sel_beats % sel_grp) != '0);

  // Results only count while a command is in flight; the count saturates at the expected total.
  always_comb begin
    res_cnt_d = res_cnt_q;
    if (mmu_valid_out && (state_q == ISSUE || state_q == DRAIN) && res_cnt_q != exp_q)
      res_cnt_d = res_cnt_q + 1'b1;
  end
  assign res_met = (res_cnt_d == exp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      op_q          <= '0;
      stage_q       <= '0;
      beats_q       <= '0;
      exp_q         <= '0;
      beat_cnt_q    <= '0;
      res_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      cfg_bad_q     <= 1'b0;
      tmo_err_q     <= 1'b0;
      req_ready_q   <= '0;
      valid_in_q    <= 1'b0;
      done_q        <= 1'b0;
      done_id_q     <= '0;
      err_cfg_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      req_ready_q   <= '0;
      done_q        <= 1'b0;
      done_id_q     <= '0;
      err_cfg_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      res_cnt_q     <= res_cnt_d;
      case (state_q)
        IDLE: begin
          if (|req_valid && feed_ready) begin
            req_ready_q <= gnt;
            rr_ptr_q    <= gnt_idx;
            id_q        <= gnt_idx;
            op_q        <= sel_op;
            stage_q     <= sel_stage;
            beats_q     <= sel_beats;
            exp_q       <= sel_beats / sel_grp;
            cfg_bad_q   <= sel_bad;
            state_q     <= sel_bad ? DONE : ISSUE;
          end
        end
        // The burst must stay gap-free: the MMU restarts its group count on any valid gap.
        ISSUE: begin
          if (beat_cnt_q == beats_q) begin
            valid_in_q <= 1'b0;
            state_q    <= DRAIN;
          end else begin
            valid_in_q <= 1'b1;
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (res_met) begin
            state_q <= DONE;
          end else if (tmo_cnt_q == TMO_W'(TIMEOUT)) begin
            tmo_err_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q        <= 1'b1;
          done_id_q     <= id_q;
          err_cfg_q     <= cfg_bad_q;
          err_timeout_q <= tmo_err_q;
          beat_cnt_q    <= '0;
          res_cnt_q     <= '0;
          tmo_cnt_q     <= '0;
          cfg_bad_q     <= 1'b0;
          tmo_err_q     <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign mmu_valid_in = valid_in_q;
  assign mmu_op_code  = op_q;
  assign mmu_stage    = stage_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign done_id      = done_id_q;
  assign err_cfg      = err_cfg_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_mmu_cmd_scheduler.sv
// Bench for mmu_cmd_scheduler: a per-command timeline model drives expectations that a
// negedge process compares every cycle, plus literal checks on burst length, latency and grants.
module tb_mmu_cmd_scheduler;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [5:0]  req_op_code = '0;
  logic [3:0]  req_stage = '0;
  logic [23:0] req_beats = '0;
  logic        feed_ready = 1'b0;
  logic        mmu_valid_in;
  logic [2:0]  mmu_op_code;
  logic [1:0]  mmu_stage;
  logic        mmu_valid_out = 1'b0;
  logic        busy, done, err_cfg, err_timeout;
  logic [0:0]  done_id;

  mmu_cmd_scheduler #(.NUM_REQ(2), .BEAT_W(12), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op_code(req_op_code), .req_stage(req_stage), .req_beats(req_beats),
    .feed_ready(feed_ready), .mmu_valid_in(mmu_valid_in), .mmu_op_code(mmu_op_code),
    .mmu_stage(mmu_stage), .mmu_valid_out(mmu_valid_out), .busy(busy), .done(done),
    .done_id(done_id), .err_cfg(err_cfg), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int e_ready = 0, e_vin = 0, e_op = 0, e_stage = 0, e_busy = 0;
  int e_done = 0, e_id = 0, e_ecfg = 0, e_etmo = 0;
  int m_rr = 0, m_op = 0, m_stage = 0;

  int run_len = 0, last_burst = 0, lat_cnt = 0, last_lat = 0;
  int last_id = 0, last_ecfg = 0, last_etmo = 0, vin_seen = 0;
  int grants[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready", int'(req_ready), e_ready);
    chk("mmu_valid_in", int'(mmu_valid_in), e_vin);
    chk("mmu_op_code", int'(mmu_op_code), e_op);
    chk("mmu_stage", int'(mmu_stage), e_stage);
    chk("busy", int'(busy), e_busy);
    chk("done", int'(done), e_done);
    chk("err_cfg", int'(err_cfg), e_ecfg);
    chk("err_timeout", int'(err_timeout), e_etmo);
    if (e_done != 0) chk("done_id", int'(done_id), e_id);
    if (mmu_valid_in) begin run_len++; vin_seen = 1; end
    else if (run_len > 0) begin last_burst = run_len; run_len = 0; end
    if (req_ready != 2'b00) begin
      lat_cnt = 0;
      grants.push_back(req_ready[1] ? 1 : 0);
    end else lat_cnt++;
    if (done) begin
      last_lat = lat_cnt; last_id = int'(done_id);
      last_ecfg = int'(err_cfg); last_etmo = int'(err_timeout);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    e_ready = 0; e_vin = 0; e_busy = 0; e_done = 0; e_id = 0; e_ecfg = 0; e_etmo = 0;
    e_op = m_op; e_stage = m_stage;
    mmu_valid_out = 1'b0;
  endtask

  task automatic set_req(input int r, input int op, input int st, input int bt);
    req_op_code = (req_op_code & ~(6'h7 << (3*r))) | (6'(op) << (3*r));
    req_stage   = (req_stage & ~(4'h3 << (2*r))) | (4'(st) << (2*r));
    req_beats   = (req_beats & ~(24'hFFF << (12*r))) | (24'(bt) << (12*r));
  endtask

  function automatic int grp(input int op, input int st);
    case (op)
      1: return 2 * (1 << st);
      3: return 2;
      5: return 8 * (1 << st);
      default: return 1;
    endcase
  endfunction

  // Timeline of one command, k = cycles after the req_ready cycle (k=-1 is the current cycle).
  // Results arrive at k in [r0, r0+nres) and at k == rlate; abort_k triggers an async reset.
  task automatic cmd(input int mask, input int r0, input int nres, input int rlate, input int abort_k);
    int g, op, st, bt, expn, cnt, kx;
    bit bad, terr, res;
    req_valid  = req_valid | 2'(mask);
    feed_ready = 1'b1;
    g = -1;
    for (int i = 1; i <= 2; i++) begin
      int c;
      c = (m_rr + i) % 2;
      if (g < 0 && ((int'(req_valid) >> c) & 1) != 0) g = c;
    end
    op   = (int'(req_op_code) >> (3*g)) & 7;
    st   = (int'(req_stage) >> (2*g)) & 3;
    bt   = (int'(req_beats) >> (12*g)) & 12'hFFF;
    expn = bt / grp(op, st);
    bad  = (bt == 0) || (bt % grp(op, st) != 0);
    m_rr = g;
    cnt = 0; kx = -1; terr = 0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (k == 0) begin
        m_op = op; m_stage = st;
        e_ready = 1 << g;
        req_valid = req_valid & ~2'(1 << g);
      end
      e_op = m_op; e_stage = m_stage;
      if (k >= 1) feed_ready = 1'b0;
      res = (k >= r0 && k < r0 + nres) || (k == rlate);
      mmu_valid_out = res;
      if (k == abort_k) begin
        chk("pre_rst_vin", int'(mmu_valid_in), 1);
        #2;
        rst_n = 1'b0;
        req_valid = '0; mmu_valid_out = 1'b0;
        m_rr = 0; m_op = 0; m_stage = 0;
        e_ready = 0; e_vin = 0; e_busy = 0; e_op = 0; e_stage = 0;
        #1;
        chk("rst_async_vin", int'(mmu_valid_in), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_op", int'(mmu_op_code), 0);
        tick(); tick();
        rst_n = 1'b1;
        return;
      end
      if (bad) begin
        e_busy = (k == 0) ? 1 : 0;
        if (k == 1) begin e_done = 1; e_id = g; e_ecfg = 1; return; end
      end else begin
        e_vin  = (k >= 1 && k <= bt) ? 1 : 0;
        e_busy = (kx < 0 || k == kx + 1) ? 1 : 0;
        if (kx < 0 && res && cnt < expn) cnt++;
        if (kx < 0 && k > bt) begin
          if (cnt >= expn) kx = k;
          else if (k - bt - 1 == TMO) begin kx = k; terr = 1; end
        end
        if (kx >= 0 && k == kx + 2) begin
          e_busy = 0; e_done = 1; e_id = g; e_etmo = terr;
          return;
        end
      end
    end
    chk("cmd_cycle_budget", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(req_ready), 0);
    chk("reset_done", int'(done), 0);
    rst_n = 1'b1;
    tick(); tick();

    // op0, 4 beats, 4 results; an extra result pulse in DONE must be ignored
    set_req(0, 0, 0, 4);
    cmd(1, 2, 4, 6, -1);
    tick();
    chk("t1_burst", last_burst, 4);
    chk("t1_latency", last_lat, 7);
    chk("t1_id", last_id, 0);

    // op1 stage1 -> group 4: 8 beats, 2 results
    set_req(0, 1, 1, 8);
    cmd(1, 4, 2, -1, -1);
    tick();
    chk("t2_burst", last_burst, 8);
    chk("t2_latency", last_lat, 11);
    chk("t2_op_held", int'(mmu_op_code), 1);

    // op5 stage0 -> group 8: 12 beats is a bad config
    set_req(1, 5, 0, 12);
    vin_seen = 0;
    cmd(2, 0, 0, -1, -1);
    tick();
    chk("t4_latency", last_lat, 1);
    chk("t4_err_cfg", last_ecfg, 1);
    chk("t4_no_valid", vin_seen, 0);

    // op3, 4 beats, only one of two results: timeout; then second result on the timeout cycle
    set_req(1, 3, 0, 4);
    cmd(2, 3, 1, -1, -1);
    tick();
    chk("t5_latency", last_lat, 262);
    chk("t5_err_tmo", last_etmo, 1);
    cmd(2, 3, 1, 260, -1);
    tick();
    chk("t5b_latency", last_lat, 262);
    chk("t5b_err_tmo", last_etmo, 0);

    // pending request with feed_ready low: no grant; then reset mid-burst
    set_req(0, 0, 0, 8);
    req_valid = 2'b01;
    feed_ready = 1'b0;
    repeat (5) tick();
    chk("t6_no_grant", int'(req_ready), 0);
    chk("t6_idle", int'(busy), 0);
    cmd(1, 0, 0, -1, 3);
    repeat (2) tick();

    // both requesters back to back from reset: grants 1,0,1,0
    set_req(0, 0, 0, 2);
    set_req(1, 2, 0, 3);
    grants.delete();
    cmd(3, 1, 3, -1, -1);
    cmd(3, 1, 3, -1, -1);
    cmd(3, 1, 3, -1, -1);
    cmd(3, 1, 3, -1, -1);
    tick();
    chk("t3_ngrants", grants.size(), 4);
    chk("t3_g0", grants[0], 1);
    chk("t3_g1", grants[1], 0);
    chk("t3_g2", grants[2], 1);
    chk("t3_g3", grants[3], 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
